// File: rtl/pattern_chk_pkg.sv
// Shared types and helpers for the pattern response checker.
// Holds the FSM state encoding, the default MISR polynomial and the MISR step function.
package pattern_chk_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    // Widest signature misr_step can handle; callers zero-extend to this width.
    localparam int unsigned MAX_W = 32;

    // One Galois MISR step over the low 'width' bits: shift, fold feedback, xor data.
    function automatic logic [MAX_W-1:0] misr_step(
        input logic [MAX_W-1:0] sig,
        input logic [MAX_W-1:0] poly,
        input logic [MAX_W-1:0] data,
        input int unsigned      width
    );
        logic [MAX_W-1:0] mask;
        logic             msb;
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        msb  = sig[5'(width - 1)];
        return ((sig << 1) ^ (msb ? poly : '0) ^ data) & mask;
    endfunction

endpackage

// File: rtl/pattern_misr_lfsr.sv
// Signature register of the response compactor.
// Loads a seed or advances one MISR step per accepted sample.
module pattern_misr_lfsr
    import pattern_chk_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [SIG_W-1:0] seed,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (step) begin
            sig_d = SIG_W'(misr_step(MAX_W'(sig_q), MAX_W'(POLY), MAX_W'(data), SIG_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/pattern_resp_misr.sv
// Response compactor: folds a window of pattern outputs into a MISR signature,
// counts output toggles, and hands the result over with valid/ready.
module pattern_resp_misr
    import pattern_chk_pkg::*;
#(
    parameter int unsigned      DATA_W = 11,
    parameter int unsigned      SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY),
    parameter int unsigned      WIN_W  = 16
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              clr,
    input  logic              start,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [SIG_W-1:0]  seed,
    input  logic [DATA_W-1:0] resp_in,
    input  logic              resp_vld,
    output logic              busy,
    output logic [SIG_W-1:0]  sig_out,
    output logic [WIN_W-1:0]  toggle_cnt,
    output logic              sig_vld,
    input  logic              sig_rdy
);

    state_e            state_q, state_d;
    logic [WIN_W-1:0]  rem_q, rem_d;
    logic [WIN_W-1:0]  tog_q, tog_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_ok_q, prev_ok_d;
    logic              sig_load;
    logic              sig_step;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        tog_d     = tog_q;
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        sig_load  = 1'b0;
        sig_step  = 1'b0;
        // clr overrides everything but keeps the last result visible
        if (clr) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && (win_len != '0)) begin
                        state_d   = StRun;
                        rem_d     = win_len;
                        tog_d     = '0;
                        prev_ok_d = 1'b0;
                        sig_load  = 1'b1;
                    end
                end
                StRun: begin
                    if (resp_vld) begin
                        sig_step  = 1'b1;
                        rem_d     = rem_q - WIN_W'(1);
                        prev_d    = resp_in;
                        prev_ok_d = 1'b1;
                        if (prev_ok_q && (resp_in != prev_q) && (tog_q != '1)) begin
                            tog_d = tog_q + WIN_W'(1);
                        end
                        if (rem_q == WIN_W'(1)) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (sig_rdy) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            tog_q     <= '0;
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            tog_q     <= tog_d;
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
        end
    end

    pattern_misr_lfsr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_lfsr (
        .clk  (blif_clk_net),
        .rst  (blif_reset_net),
        .load (sig_load),
        .step (sig_step),
        .seed (seed),
        .data (SIG_W'(resp_in)),
        .sig  (sig_out)
    );

    assign busy       = (state_q == StRun) || (state_q == StHold);
    assign sig_vld    = (state_q == StHold);
    assign toggle_cnt = tog_q;

endmodule
